// File: rtl/comp_distance.sv
// comp_distance: closed-tour length of a 30-city route for the route optimizer.
// A route is latched on start; legs {city_k, city_(k+1 mod 30)} are looked up
// in a fixed synchronous distance ROM and summed. A one-cycle done reports the
// result, which then stays on out until the next completed evaluation or reset.
module comp_distance #(
  parameter int NCITY = 30,
  parameter int CBITS = 5,
  parameter int DBITS = 7,
  parameter int OBITS = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NCITY*CBITS-1:0] in,
  output logic [OBITS-1:0]       out,
  output logic                   done,
  output logic [2*CBITS-1:0]     dout_debug
);

  localparam int RBITS = NCITY * CBITS;
  localparam int ABITS = 2 * CBITS;
  localparam logic [CBITS-1:0] LAST_LEG = CBITS'(NCITY - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [RBITS-1:0]   route_q, route_d;
  logic [CBITS-1:0]   leg_q, leg_d;
  logic [ABITS-1:0]   addr_q, addr_d;
  logic [DBITS-1:0]   rom_q, rom_d;
  logic [OBITS-1:0]   acc_q, acc_d;
  logic [OBITS-1:0]   out_q, out_d;
  logic               done_q, done_d;

  // Distance ROM contents: Manhattan distance on an 8x4 grid, scaled by 12.
  // Column is city[2:0], row is city[4:3]; result range is 0..120.
  function automatic logic [DBITS-1:0] dist_f(input logic [CBITS-1:0] a,
                                              input logic [CBITS-1:0] b);
    logic [2:0] dx;
    logic [1:0] dy;
    logic [3:0] sum;
    logic [7:0] prod;
    dx   = (a[2:0] >= b[2:0]) ? (a[2:0] - b[2:0]) : (b[2:0] - a[2:0]);
    dy   = (a[4:3] >= b[4:3]) ? (a[4:3] - b[4:3]) : (b[4:3] - a[4:3]);
    sum  = {1'b0, dx} + {2'b00, dy};
    prod = {4'b0000, sum} * 8'd12;
    return prod[DBITS-1:0];
  endfunction

  // Pick city k out of a packed route (city 0 in the LSBs).
  function automatic logic [CBITS-1:0] city_at(input logic [RBITS-1:0] r,
                                               input logic [CBITS-1:0] k);
    logic [7:0] base;
    base = {3'b000, k} * 8'd5;
    return r[base +: CBITS];
  endfunction

  // Successor leg index, wrapping the last city back to the first.
  function automatic logic [CBITS-1:0] next_idx(input logic [CBITS-1:0] k);
    logic [CBITS-1:0] n;
    if (k == LAST_LEG) begin
      n = {CBITS{1'b0}};
    end else begin
      n = k + {{(CBITS-1){1'b0}}, 1'b1};
    end
    return n;
  endfunction

  // Next-state logic: leg addressing, ROM lookup, accumulation and result.
  always_comb begin
    state_d = state_q;
    route_d = route_q;
    leg_d   = leg_q;
    addr_d  = addr_q;
    acc_d   = acc_q;
    out_d   = out_q;
    done_d  = 1'b0;
    // The ROM is read every cycle; data lags the address by one clock.
    rom_d   = dist_f(addr_q[ABITS-1:CBITS], addr_q[CBITS-1:0]);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Route is captured here so later changes on in are ignored.
          route_d = in;
          acc_d   = {OBITS{1'b0}};
          leg_d   = {CBITS{1'b0}};
          addr_d  = {in[CBITS-1:0], in[2*CBITS-1:CBITS]};
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        // rom_q holds the distance of leg (leg_q-1) once leg 0 has been read.
        if (leg_q != {CBITS{1'b0}}) begin
          acc_d = acc_q + {{(OBITS-DBITS){1'b0}}, rom_q};
        end else begin
          acc_d = acc_q;
        end
        if (leg_q == LAST_LEG) begin
          // Last address stays on the bus; its data is summed in FINISH.
          state_d = S_FINISH;
        end else begin
          leg_d   = leg_q + {{(CBITS-1){1'b0}}, 1'b1};
          addr_d  = {city_at(route_q, leg_q + {{(CBITS-1){1'b0}}, 1'b1}),
                     city_at(route_q, next_idx(leg_q + {{(CBITS-1){1'b0}}, 1'b1}))};
          state_d = S_RUN;
        end
      end

      S_FINISH: begin
        out_d   = acc_q + {{(OBITS-DBITS){1'b0}}, rom_q};
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      route_q <= {RBITS{1'b0}};
      leg_q   <= {CBITS{1'b0}};
      addr_q  <= {ABITS{1'b0}};
      rom_q   <= {DBITS{1'b0}};
      acc_q   <= {OBITS{1'b0}};
      out_q   <= {OBITS{1'b0}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
      leg_q   <= leg_d;
      addr_q  <= addr_d;
      rom_q   <= rom_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign out        = out_q;
  assign done       = done_q;
  assign dout_debug = addr_q;

endmodule

// File: tb/tb_comp_distance.sv
// Directed self-checking bench for comp_distance.
module tb_comp_distance;

  logic         clk;
  logic         rst;
  logic         start;
  logic [149:0] in_r;
  logic [11:0]  out;
  logic         done;
  logic [9:0]   dout_debug;

  int checks;
  int failures;

  comp_distance dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in         (in_r),
    .out        (out),
    .done       (done),
    .dout_debug (dout_debug)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Start one evaluation and wait (bounded) for done; n = cycles after E0.
  task automatic do_eval(input logic [149:0] r, input string tag, output int n,
                         output logic [9:0] d1, output logic [9:0] d2);
    in_r  = r;
    start = 1'b1;
    step();
    start = 1'b0;
    d1 = dout_debug;
    d2 = 10'd0;
    chk({tag, "_done_low_after_start"}, {31'd0, done}, 32'd0);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i == 1) d2 = dout_debug;
      if (done) begin
        n = i;
        break;
      end
    end
    chk({tag, "_latency"}, n, 32'd31);
  endtask

  logic [149:0] p_alt, p_max, p_id;
  int           n, n2, dones;
  logic [9:0]   d1, d2;
  logic [11:0]  out_at_done;

  initial begin
    checks   = 0;
    failures = 0;
    clk      = 1'b0;
    rst      = 1'b1;
    start    = 1'b0;
    in_r     = 150'd3;

    for (int k = 0; k < 30; k++) begin
      p_alt[5*k +: 5] = (k % 2 == 0) ? 5'd6 : 5'd0;
      p_max[5*k +: 5] = (k % 2 == 0) ? 5'd0 : 5'd31;
      p_id[5*k +: 5]  = 5'(k);
    end

    // Reset, then idle with start low.
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_out", {20'd0, out}, 32'd0);
      chk("idle_done", {31'd0, done}, 32'd0);
      chk("idle_dbg", {22'd0, dout_debug}, 32'd0);
    end

    // Alternating 6,0 route: 30 legs of 72.
    do_eval(p_alt, "alt", n, d1, d2);
    chk("alt_out", {20'd0, out}, 32'd2160);
    chk("alt_dbg_leg0", {22'd0, d1}, 32'h0C0);
    chk("alt_dbg_leg1", {22'd0, d2}, 32'h006);
    chk("alt_dbg_end", {22'd0, dout_debug}, 32'h006);
    step();
    chk("alt_done_one_cycle", {31'd0, done}, 32'd0);
    chk("alt_out_hold", {20'd0, out}, 32'd2160);
    step();

    // Degenerate route: all cities 0.
    do_eval(150'd0, "zero", n, d1, d2);
    chk("zero_out", {20'd0, out}, 32'd0);
    step();

    // Maximum route: alternating 0 and 31, each leg 120.
    do_eval(p_max, "max", n, d1, d2);
    chk("max_out", {20'd0, out}, 32'd3600);
    step();

    // Identity route: 26 legs of 12, four legs of 96.
    do_eval(p_id, "id", n, d1, d2);
    chk("id_out", {20'd0, out}, 32'd696);
    step();

    // Change in and pulse start during RUN: ignored.
    in_r  = p_alt;
    start = 1'b1;
    step();
    start = 1'b0;
    n = -1;
    dones = 0;
    out_at_done = 12'd0;
    for (int i = 1; i <= 45; i++) begin
      if (i == 5) begin
        in_r  = p_max;
        start = 1'b1;
      end
      step();
      start = 1'b0;
      if (done) begin
        dones++;
        if (n < 0) begin
          n = i;
          out_at_done = out;
        end
      end
    end
    chk("robust_latency", n, 32'd31);
    chk("robust_dones", dones, 32'd1);
    chk("robust_out", {20'd0, out_at_done}, 32'd2160);

    // Reset mid-RUN: evaluation abandoned, no done.
    in_r  = p_id;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_out", {20'd0, out}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_dbg", {22'd0, dout_debug}, 32'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done) dones++;
    end
    chk("midrst_no_done", dones, 32'd0);
    chk("midrst_out_after", {20'd0, out}, 32'd0);

    // Back-to-back: start accepted in the done cycle.
    do_eval(p_alt, "b2b_first", n, d1, d2);
    chk("b2b_first_out", {20'd0, out}, 32'd2160);
    in_r  = p_id;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("b2b_done_low", {31'd0, done}, 32'd0);
    n2 = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (done) begin
        n2 = i;
        break;
      end
    end
    chk("b2b_second_latency", n2, 32'd31);
    chk("b2b_second_out", {20'd0, out}, 32'd696);
    step();
    chk("b2b_done_one_cycle", {31'd0, done}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
